// File: rtl/fft_twiddle_pkg.sv
// Shared twiddle definitions: quadrant encoding, ROM depth helper and the
// quarter-wave cosine table (N=128 master table, scaled by 2^9 = unity for an
// 11-bit coefficient). Smaller N reuse it with a stride, since cos(2*pi*r/N)
// equals the master entry at r*(128/N).
package fft_twiddle_pkg;

  localparam int TAB_LOG2N = 7;
  localparam int TAB_RW    = TAB_LOG2N - 2;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_t;

  // Entries per quarter wave for a given FFT size.
  function automatic int rom_depth(input int log2n);
    return 1 << (log2n - 2);
  endfunction

  // round(cos(2*pi*i/128) * 512), half away from zero, i = 0..32.
  // Entry 32 (cos 90 deg) lets sin(r) be read as COS_TAB[32 - r].
  localparam logic signed [10:0] COS_TAB [0:32] = '{
    11'sd512, 11'sd511, 11'sd510, 11'sd506, 11'sd502, 11'sd497, 11'sd490, 11'sd482,
    11'sd473, 11'sd463, 11'sd452, 11'sd439, 11'sd426, 11'sd411, 11'sd396, 11'sd379,
    11'sd362, 11'sd344, 11'sd325, 11'sd305, 11'sd284, 11'sd263, 11'sd241, 11'sd219,
    11'sd196, 11'sd172, 11'sd149, 11'sd124, 11'sd100, 11'sd75,  11'sd50,  11'sd25,
    11'sd0
  };

endpackage

// File: rtl/twiddle_mult_pipe_if.sv
// Streaming sample/result bus of the twiddle multiplier.
interface twiddle_mult_pipe_if #(
  parameter int NBITS     = 12,
  parameter int NBITS_out = 24,
  parameter int LOG2N     = 7
);
  logic                   in_valid;
  logic [2*NBITS-1:0]     muestra;
  logic                   tw_ext;
  logic [LOG2N-1:0]       tw_idx_in;
  logic                   sync;
  logic                   out_valid;
  logic [2*NBITS_out-1:0] result;
  logic [LOG2N-1:0]       tw_idx_out;

  modport master (
    output in_valid, muestra, tw_ext, tw_idx_in, sync,
    input  out_valid, result, tw_idx_out
  );

  modport slave (
    input  in_valid, muestra, tw_ext, tw_idx_in, sync,
    output out_valid, result, tw_idx_out
  );
endinterface

// File: rtl/twiddle_rom_q.sv
// Quarter-wave twiddle ROM: r in, registered {C, S} out.
module twiddle_rom_q
  import fft_twiddle_pkg::*;
#(
  parameter int LOG2N      = 7,
  parameter int NBITScoeff = 11
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LOG2N-3:0]             r,
  output logic signed [NBITScoeff-1:0] c,
  output logic signed [NBITScoeff-1:0] s
);
  // Stride into the master table for smaller N.
  localparam int SHIFT = TAB_LOG2N - LOG2N;
  localparam logic [TAB_RW:0] QW = (TAB_RW+1)'(rom_depth(TAB_LOG2N));

  logic [TAB_RW:0] cidx, sidx;

  // Map r onto master-table addresses for cos and its complement for sin.
  always_comb begin
    cidx = (TAB_RW+1)'(r) << SHIFT;
    sidx = QW - cidx;
  end

  // Registered lookup.
  always_ff @(posedge clk) begin
    if (rst) begin
      c <= '0;
      s <= '0;
    end else begin
      c <= NBITScoeff'(COS_TAB[cidx]);
      s <= NBITScoeff'(COS_TAB[sidx]);
    end
  end
endmodule

// File: rtl/twiddle_mult_pipe.sv
// Pipelined complex multiply by W_N^k = exp(-j*2*pi*k/N), k from an internal
// frame counter or an external index. Quarter-wave ROM plus (-j)^q rotation.
// Three register stages; data regs load every cycle, out_valid qualifies.
module twiddle_mult_pipe
  import fft_twiddle_pkg::*;
#(
  parameter int NBITS      = 12,
  parameter int NBITScoeff = 11,
  parameter int NBITS_out  = NBITS + NBITScoeff + 1,
  parameter int LOG2N      = 7
) (
  input logic                clk,
  input logic                rst,
  twiddle_mult_pipe_if.slave bus
);
  localparam int NP = NBITS + NBITScoeff;

  logic [LOG2N-1:0]              cnt, k_sel;
  logic [3:1]                    vld_pipe;
  logic [3:1][LOG2N-1:0]         k_pipe;
  quad_t                         q1, q2;
  logic signed [NBITS-1:0]       mr1, mi1;
  logic signed [NBITScoeff-1:0]  c1, s1;
  logic signed [NP-1:0]          p_rc, p_is, p_ic, p_rs;
  logic signed [NBITS_out-1:0]   r0, i0, re_rot, im_rot, re3, im3;

  // Sync forces k=0 for the current sample when the counter is in use.
  always_comb begin
    k_sel = bus.tw_ext ? bus.tw_idx_in : (bus.sync ? '0 : cnt);
  end

  // Frame counter: advances per accepted sample, sync restarts the frame.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (bus.sync)
      cnt <= bus.in_valid ? LOG2N'(1) : '0;
    else if (bus.in_valid)
      cnt <= cnt + LOG2N'(1);
  end

  // Valid shift register, one bit per stage.
  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else     vld_pipe <= {vld_pipe[2:1], bus.in_valid};
  end

  twiddle_rom_q #(
    .LOG2N      (LOG2N),
    .NBITScoeff (NBITScoeff)
  ) u_rom (
    .clk (clk),
    .rst (rst),
    .r   (k_sel[LOG2N-3:0]),
    .c   (c1),
    .s   (s1)
  );

  // S1: capture sample, quadrant and index alongside the ROM read.
  always_ff @(posedge clk) begin
    if (rst) begin
      mr1       <= '0;
      mi1       <= '0;
      q1        <= QUAD_0;
      k_pipe[1] <= '0;
    end else begin
      mr1       <= bus.muestra[2*NBITS-1:NBITS];
      mi1       <= bus.muestra[NBITS-1:0];
      q1        <= quad_t'(k_sel[LOG2N-1 -: 2]);
      k_pipe[1] <= k_sel;
    end
  end

  // S2: the four partial products.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_rc      <= '0;
      p_is      <= '0;
      p_ic      <= '0;
      p_rs      <= '0;
      q2        <= QUAD_0;
      k_pipe[2] <= '0;
    end else begin
      p_rc      <= NP'(mr1) * NP'(c1);
      p_is      <= NP'(mi1) * NP'(s1);
      p_ic      <= NP'(mi1) * NP'(c1);
      p_rs      <= NP'(mr1) * NP'(s1);
      q2        <= q1;
      k_pipe[2] <= k_pipe[1];
    end
  end

  // First-quadrant sums, then rotate by (-j)^q. Magnitudes stay below
  // 2^(NBITS_out-2) so negation cannot overflow.
  always_comb begin
    r0     = NBITS_out'(p_rc) + NBITS_out'(p_is);
    i0     = NBITS_out'(p_ic) - NBITS_out'(p_rs);
    re_rot = r0;
    im_rot = i0;
    case (q2)
      QUAD_1: begin re_rot = i0;  im_rot = -r0; end
      QUAD_2: begin re_rot = -r0; im_rot = -i0; end
      QUAD_3: begin re_rot = -i0; im_rot = r0;  end
      default: ;
    endcase
  end

  // S3: registered rotated result.
  always_ff @(posedge clk) begin
    if (rst) begin
      re3       <= '0;
      im3       <= '0;
      k_pipe[3] <= '0;
    end else begin
      re3       <= re_rot;
      im3       <= im_rot;
      k_pipe[3] <= k_pipe[2];
    end
  end

  assign bus.out_valid  = vld_pipe[3];
  assign bus.result     = {re3, im3};
  assign bus.tw_idx_out = k_pipe[3];
endmodule

// File: tb/tb_twiddle_mult_pipe.sv
// Scoreboard bench for twiddle_mult_pipe: expected results come from a
// floating-point twiddle model and are checked in order as out_valid fires.
module tb_twiddle_mult_pipe;
  localparam int NBITS = 12;
  localparam int NC    = 11;
  localparam int NO    = NBITS + NC + 1;
  localparam int LOG2N = 7;
  localparam int N     = 1 << LOG2N;
  localparam real SCALE = real'(1 << (NC - 2));

  typedef struct {
    int     k;
    longint re;
    longint im;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sbq[$];
  int   mcnt = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  twiddle_mult_pipe_if #(.NBITS(NBITS), .NBITS_out(NO), .LOG2N(LOG2N)) bus ();

  twiddle_mult_pipe #(
    .NBITS(NBITS), .NBITScoeff(NC), .NBITS_out(NO), .LOG2N(LOG2N)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic signed [NO-1:0] act_re, act_im;
  assign act_re = bus.result[2*NO-1:NO];
  assign act_im = bus.result[NO-1:0];

  function automatic longint rnd(input real x);
    if (x >= 0.0) return longint'($floor(x + 0.5));
    else          return -longint'($floor(-x + 0.5));
  endfunction

  function automatic void model(input int k, input longint re, input longint im,
                                output longint er, output longint ei);
    int q, r;
    real ang;
    longint c, s, r0, i0;
    q   = k / (N / 4);
    r   = k % (N / 4);
    ang = 2.0 * 3.14159265358979323846 * r / N;
    c   = rnd($cos(ang) * SCALE);
    s   = rnd($sin(ang) * SCALE);
    r0  = re * c + im * s;
    i0  = im * c - re * s;
    case (q)
      0:       begin er = r0;  ei = i0;  end
      1:       begin er = i0;  ei = -r0; end
      2:       begin er = -r0; ei = -i0; end
      default: begin er = -i0; ei = r0;  end
    endcase
  endfunction

  // One stimulus cycle; pushes the expected result for valid samples.
  task automatic drv(input bit v, input int re, input int im,
                     input bit ext, input int idx, input bit sy);
    int k;
    longint er, ei;
    bus.in_valid  = v;
    bus.muestra   = {12'(re), 12'(im)};
    bus.tw_ext    = ext;
    bus.tw_idx_in = 7'(idx);
    bus.sync      = sy;
    k = ext ? idx : (sy ? 0 : mcnt);
    if (v) begin
      model(k, re, im, er, ei);
      sbq.push_back('{k, er, ei});
    end
    if (sy)     mcnt = v ? 1 : 0;
    else if (v) mcnt = (mcnt + 1) % N;
    @(posedge clk); #1;
  endtask

  // Output monitor: every out_valid must match the oldest pending sample.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      exp_t e;
      chk_cnt++;
      if (sbq.size() == 0) begin
        $display("FAIL stale_output: out_valid=1 k=%0d re=%0d im=%0d, none expected",
                 bus.tw_idx_out, act_re, act_im);
      end else begin
        e = sbq.pop_front();
        if (longint'(act_re) !== e.re || longint'(act_im) !== e.im ||
            int'(bus.tw_idx_out) !== e.k)
          $display("FAIL scoreboard: got k=%0d (%0d,%0d) want k=%0d (%0d,%0d)",
                   bus.tw_idx_out, act_re, act_im, e.k, e.re, e.im);
        else
          pass_cnt++;
      end
    end
  end

  task automatic test_reset();
    bus.in_valid = 0; bus.muestra = '0; bus.tw_ext = 0; bus.tw_idx_in = '0; bus.sync = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.tw_idx_out !== '0)
      $display("FAIL reset_state: out_valid=%b result=%h idx=%0d, want 0/0/0",
               bus.out_valid, bus.result, bus.tw_idx_out);
    else pass_cnt++;
    rst = 1'b0;
    mcnt = 0;
    sbq.delete();
  endtask

  task automatic test_basic();
    int ek[3] = '{32, 64, 96};
    int er[3] = '{-25600, -51200, 25600};
    int ei[3] = '{-51200, 25600, 51200};
    drv(1, 100, -50, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    chk_cnt++;
    if (bus.out_valid !== 1'b1 || act_re !== 24'sd51200 || act_im !== -24'sd25600 ||
        bus.tw_idx_out !== 7'd0)
      $display("FAIL k0_passthrough: v=%b (%0d,%0d) k=%0d want 1 (51200,-25600) k=0",
               bus.out_valid, act_re, act_im, bus.tw_idx_out);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) drv(1, 100, -50, 1, ek[i], 0);
    for (int i = 0; i < 3; i++) begin
      chk_cnt++;
      if (bus.out_valid !== 1'b1 || int'(act_re) !== er[i] || int'(act_im) !== ei[i] ||
          int'(bus.tw_idx_out) !== ek[i])
        $display("FAIL quadrant_k%0d: v=%b (%0d,%0d) k=%0d want (%0d,%0d)",
                 ek[i], bus.out_valid, act_re, act_im, bus.tw_idx_out, er[i], ei[i]);
      else pass_cnt++;
      drv(0, 0, 0, 0, 0, 0);
    end
    drv(1, 100, -50, 1, 16, 0);
    drv(0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0);
    chk_cnt++;
    if (bus.out_valid !== 1'b1 || act_re !== 24'sd18100 || act_im !== -24'sd54300)
      $display("FAIL k16_product: v=%b (%0d,%0d) want (18100,-54300)",
               bus.out_valid, act_re, act_im);
    else pass_cnt++;
    repeat (2) drv(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_internal_frame();
    drv(1, 1, 0, 0, 0, 1);
    repeat (129) drv(1, 1, 0, 0, 0, 0);
    repeat (4) drv(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_gaps_sync();
    drv(1, 3, -7, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      drv(1, 10 * i - 90, 200 - 7 * i, 0, 0, (i == 10));
      repeat ($urandom_range(1, 3)) drv(0, 0, 0, 0, 0, 0);
    end
    repeat (4) drv(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_rst_midstream();
    drv(1, 11, 22, 0, 0, 0);
    drv(1, 33, 44, 0, 0, 0);
    drv(1, 55, 66, 0, 0, 0);
    bus.in_valid = 0; bus.sync = 0; bus.tw_ext = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    sbq.delete();
    mcnt = 0;
    chk_cnt++;
    if (bus.out_valid !== 1'b0 || bus.result !== '0)
      $display("FAIL rst_flush: out_valid=%b result=%h want 0/0", bus.out_valid, bus.result);
    else pass_cnt++;
    rst = 1'b0;
    repeat (4) drv(0, 0, 0, 0, 0, 0);
    drv(1, 5, 7, 0, 0, 0);
    drv(1, -2048, -2048, 1, 16, 0);
    drv(1, -2048, -2048, 1, 112, 0);
    drv(1, 2047, -2048, 1, 48, 0);
    drv(1, -2048, 2047, 0, 0, 0);
    repeat (4) drv(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++)
      drv($urandom_range(0, 1), int'($urandom_range(0, 4095)) - 2048,
          int'($urandom_range(0, 4095)) - 2048, $urandom_range(0, 1),
          $urandom_range(0, N - 1), ($urandom_range(0, 15) == 0));
    repeat (5) drv(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_internal_frame();
    test_gaps_sync();
    test_rst_midstream();
    test_random();
    chk_cnt++;
    if (sbq.size() != 0)
      $display("FAIL drain: %0d expected results never appeared, want 0", sbq.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
